// File: rtl/camera_config_ctrl.sv
// camera_config_ctrl: walks the OV7670 config ROM and issues SCCB writes, handling end and delay markers
module camera_config_ctrl #(
  parameter int MS_CYCLES = 25000,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sccb_valid,
  input  logic              i_sccb_ready,
  output logic [7:0]        o_sccb_reg,
  output logic [7:0]        o_sccb_data,
  input  logic              i_sccb_done,
  input  logic              i_sccb_err,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int CNT_W = $clog2(255 * MS_CYCLES + 1);
  localparam logic [CNT_W-1:0] MS = CNT_W'(MS_CYCLES);
  localparam logic [ADDR_W-1:0] LAST = '1;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITE, WAIT_DONE, DELAY, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic marker, idle_start;
  assign marker = i_rom_data[15:8] == 8'hFF;
  assign idle_start = (state == IDLE || state == DONE) && i_start;
  assign o_busy = state != IDLE && state != DONE;
  assign o_done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = i_start ? FETCH : state;
      FETCH:      state_n = DECODE;
      DECODE:     state_n = !marker ? WRITE : i_rom_data[7:0] == 8'hFF ? DONE :
                            i_rom_data[7:0] == 8'h00 ? NEXT : DELAY;
      WRITE:      state_n = i_sccb_ready ? WAIT_DONE : WRITE;
      WAIT_DONE:  state_n = !i_sccb_done ? WAIT_DONE : i_sccb_err ? DONE : NEXT;
      DELAY:      state_n = cnt == '0 ? NEXT : DELAY;
      NEXT:       state_n = o_rom_addr == LAST ? DONE : FETCH;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      o_rom_addr <= '0;
      o_sccb_valid <= 1'b0;
      o_sccb_reg <= '0;
      o_sccb_data <= '0;
      o_err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (idle_start) begin
        o_rom_addr <= '0;
        o_err <= 1'b0;
      end
      if (state == DECODE) cnt <= CNT_W'(i_rom_data[7:0]) * MS - CNT_W'(1);
      if (state == DECODE && !marker) begin
        o_sccb_reg <= i_rom_data[15:8];
        o_sccb_data <= i_rom_data[7:0];
        o_sccb_valid <= 1'b1;
      end
      if (state == WRITE && i_sccb_ready) o_sccb_valid <= 1'b0;
      if (state == WAIT_DONE && i_sccb_done && i_sccb_err) o_err <= 1'b1;
      if (state == DELAY && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (state == NEXT && o_rom_addr != LAST) o_rom_addr <= o_rom_addr + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_camera_config_ctrl.sv
// tb_camera_config_ctrl: table-driven ROM scenarios with a write scoreboard and an SCCB responder model
module tb_camera_config_ctrl;
  localparam int MS = 4;
  localparam int AW = 8;
  logic clk = 0, rstn = 0, start = 0, sccb_ready = 1, sccb_done = 0, sccb_err = 0;
  logic [AW-1:0] rom_addr;
  logic [15:0] rom_data;
  logic sccb_valid, busy, done, err;
  logic [7:0] sccb_reg, sccb_data;
  logic [15:0] rom [256];
  int passed = 0, total = 0, accepts = 0, hold_left = 0, cd = 0, cyc = 0;
  bit inj_first = 0;
  int done_t[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0][15:0] r;
    logic [15:0] fill;
    int hold;
    bit inj;
    bit mid;
    int nw;
    logic [7:0] last;
    bit exp_err;
    bit gap;
    int max_cyc;
  } vec_t;
  vec_t v[7];

  camera_config_ctrl #(.MS_CYCLES(MS), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_sccb_valid(sccb_valid), .i_sccb_ready(sccb_ready), .o_sccb_reg(sccb_reg),
    .o_sccb_data(sccb_data), .i_sccb_done(sccb_done), .i_sccb_err(sccb_err),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // SCCB responder: inputs change on the falling edge, done arrives 3 cycles after accept
  always @(negedge clk) begin
    sccb_done = 0;
    sccb_err = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        sccb_done = 1;
        sccb_err = inj_first;
        inj_first = 0;
        done_t.push_back(cyc);
      end
    end
    if (sccb_valid) begin
      if (hold_left > 0) begin
        sccb_ready = 0;
        hold_left--;
        chk("hold_stable_reg_data", {sccb_reg, sccb_data}, 16'h1280);
      end else begin
        sccb_ready = 1;
        accepts++;
        if (exp_q.size() == 0) chk("extra_write", {sccb_reg, sccb_data}, 32'hFFFF_FFFF);
        else chk("write_reg_data", {sccb_reg, sccb_data}, exp_q.pop_front());
        cd = 3;
      end
    end
  end

  function automatic vec_t mk(input logic [15:0] a0, a1, a2, a3, fill, input int hold, input bit inj,
                              input bit mid, input int nw, input logic [7:0] last, input bit e,
                              input bit gap, input int max_cyc);
    vec_t t;
    t.r[0] = a0; t.r[1] = a1; t.r[2] = a2; t.r[3] = a3;
    t.fill = fill; t.hold = hold; t.inj = inj; t.mid = mid; t.nw = nw; t.last = last;
    t.exp_err = e; t.gap = gap; t.max_cyc = max_cyc;
    return t;
  endfunction

  task automatic setup(input vec_t t);
    for (int a = 0; a < 256; a++) rom[a] = t.fill;
    for (int a = 0; a < 4; a++) rom[a] = t.r[a];
    exp_q.delete();
    done_t.delete();
    accepts = 0;
    hold_left = t.hold;
    inj_first = t.inj;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) break;
      if (rom[a][15:8] != 8'hFF) begin
        exp_q.push_back(rom[a]);
        if (t.inj) break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int n;
    setup(t);
    pulse_start();
    chk($sformatf("v%0d_busy_done_err_after_start", idx), {busy, done, err}, 3'b100);
    n = 0;
    while (!done && n < t.max_cyc) begin
      @(negedge clk);
      n++;
      if (t.mid && n == 50) begin
        start = 1;
        @(negedge clk) start = 0;
        chk($sformatf("v%0d_mid_start_ignored_busy", idx), busy, 1);
      end
    end
    chk($sformatf("v%0d_done_within_bound", idx), n < t.max_cyc, 1);
    chk($sformatf("v%0d_done_busy", idx), {done, busy}, 2'b10);
    chk($sformatf("v%0d_final_addr", idx), rom_addr, t.last);
    chk($sformatf("v%0d_err", idx), err, t.exp_err);
    chk($sformatf("v%0d_accepts", idx), accepts, t.nw);
    chk($sformatf("v%0d_writes_left", idx), exp_q.size(), 0);
    if (t.gap) chk($sformatf("v%0d_delay_gap_ge_960", idx),
                   done_t.size() == 2 && done_t[1] - done_t[0] >= 240 * MS, 1);
  endtask

  initial begin
    int n;
    v[0] = mk(16'h1280, 16'hFFF0, 16'h1500, 16'hFFFF, 16'hFFFF, 0, 0, 0, 2, 3, 0, 1, 3000);
    v[1] = mk(16'h1280, 16'hFFF0, 16'h1500, 16'hFFFF, 16'hFFFF, 10, 0, 0, 2, 3, 0, 0, 3000);
    v[2] = mk(16'h1280, 16'hFFF0, 16'h1500, 16'hFFFF, 16'hFFFF, 0, 1, 0, 1, 0, 1, 0, 500);
    v[3] = mk(16'h1280, 16'hFFF0, 16'h1500, 16'hFFFF, 16'hFFFF, 0, 0, 0, 2, 3, 0, 1, 3000);
    v[4] = mk(16'hFF00, 16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 2, 0, 0, 20);
    v[5] = mk(16'h0111, 16'h0111, 16'h0111, 16'h0111, 16'h0111, 0, 0, 0, 256, 255, 0, 0, 6000);
    v[6] = mk(16'h1280, 16'hFFF0, 16'h1500, 16'hFFFF, 16'hFFFF, 0, 0, 1, 2, 3, 0, 1, 3000);
    for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done, err}, 0);
    rstn = 1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 2'b00);
    for (int i = 0; i < 7; i++) run_vec(v[i], i);
    // reset while a request is pending and never accepted
    setup(v[0]);
    hold_left = 1000;
    pulse_start();
    n = 0;
    while (!sccb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_seq_valid_seen", sccb_valid, 1);
    repeat (3) @(negedge clk);
    rstn = 0;
    #1;
    chk("mid_write_reset_outputs", {rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done, err}, 0);
    hold_left = 0;
    sccb_ready = 1;
    exp_q.delete();
    @(negedge clk) rstn = 1;
    repeat (3) @(negedge clk);
    chk("idle_after_mid_reset", {sccb_valid, busy, done}, 3'b000);
    run_vec(v[0], 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
